// File: rtl/ushift_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
package ushift_pkg;

    typedef enum logic [2:0] {
        MODE_LOAD = 3'd0,
        MODE_SHR  = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_ROR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_CLR  = 3'd5
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Internal code for a step that leaves q untouched (codes 6/7, zero-count shifts).
    localparam logic [2:0] MODE_NOP = 3'd6;

    function automatic logic is_shift_f(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) ||
               (mode == MODE_ROR) || (mode == MODE_ROL);
    endfunction

endpackage

// File: rtl/ushift_reg_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 2**26
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 32'd1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // Next prescaler value with wrap at TICK_DIV-1.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Counter and strobe; tick_r always mirrors (cnt_r == LAST).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= (TICK_DIV == 32'd1) ? 1'b1 : 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ushift_reg.sv
// Universal shift register: load / shift / rotate / clear, stepped by a prescaler tick
// with a ready/valid command handshake and a completion pulse.
module ushift_reg
    import ushift_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TICK_DIV = 2**26,
    parameter int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             so_lsb,
    output logic             so_msb,
    output logic             tick,
    output logic             done
);

    state_e           state_r,    state_nxt_s;
    logic [2:0]       mode_r,     mode_nxt_s;
    logic [CNT_W-1:0] rem_r,      rem_nxt_s;
    logic [WIDTH-1:0] d_r,        d_nxt_s;
    logic [WIDTH-1:0] q_r,        q_nxt_s;
    logic             done_r,     done_nxt_s;
    logic             tick_s;

    function automatic logic [WIDTH-1:0] step_f(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             si
    );
        case (mode)
            MODE_LOAD: step_f = ld;
            MODE_SHR:  step_f = {si, cur[WIDTH-1:1]};
            MODE_SHL:  step_f = {cur[WIDTH-2:0], si};
            MODE_ROR:  step_f = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  step_f = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_CLR:  step_f = '0;
            default:   step_f = cur;
        endcase
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Command acceptance, step sequencing and abort handling.
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        rem_nxt_s   = rem_r;
        d_nxt_s     = d_r;
        q_nxt_s     = q_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = ST_RUN;
                    d_nxt_s     = d_in;
                    // A zero-count shift still takes one step, folded into a no-op.
                    if (is_shift_f(cmd_mode) && (cmd_count != '0)) begin
                        mode_nxt_s = cmd_mode;
                        rem_nxt_s  = cmd_count;
                    end else if (is_shift_f(cmd_mode)) begin
                        mode_nxt_s = MODE_NOP;
                        rem_nxt_s  = CNT_W'(1);
                    end else begin
                        mode_nxt_s = cmd_mode;
                        rem_nxt_s  = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s) begin
                    q_nxt_s   = step_f(mode_r, q_r, d_r, ser_in);
                    rem_nxt_s = rem_r - CNT_W'(1);
                    if (rem_r == CNT_W'(1)) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= 3'd0;
            rem_r   <= '0;
            d_r     <= '0;
            q_r     <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            rem_r   <= rem_nxt_s;
            d_r     <= d_nxt_s;
            q_r     <= q_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign q         = q_r;
    assign so_lsb    = q_r[0];
    assign so_msb    = q_r[WIDTH-1];
    assign tick      = tick_s;
    assign done      = done_r;

endmodule

// File: tb/tb_ushift_reg.sv
// Self-checking bench for ushift_reg: directed scenarios plus randomized commands
// compared against an arithmetic reference model.
module tb_ushift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_valid3 = 1'b0;
    logic [2:0] cmd_mode = 3'd0;
    logic [2:0] cmd_count = 3'd0;
    logic [3:0] d_in = 4'd0;
    logic       ser_in = 1'b0;
    logic       abort = 1'b0;

    logic       cmd_ready, so_lsb, so_msb, tick, done;
    logic [3:0] q;
    logic       cmd_ready3, so_lsb3, so_msb3, tick3, done3;
    logic [3:0] q3;

    int checks = 0;
    int errors = 0;
    logic [3:0] ref_q = 4'd0;
    logic [3:0] ref3 = 4'd0;
    int cyc3 = 0;

    always #5 clk = ~clk;

    ushift_reg #(.WIDTH(4), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_count(cmd_count), .d_in(d_in), .ser_in(ser_in),
        .abort(abort), .q(q), .so_lsb(so_lsb), .so_msb(so_msb), .tick(tick), .done(done)
    );

    ushift_reg #(.WIDTH(4), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_mode(cmd_mode), .cmd_count(cmd_count), .d_in(d_in), .ser_in(ser_in),
        .abort(abort), .q(q3), .so_lsb(so_lsb3), .so_msb(so_msb3), .tick(tick3), .done(done3)
    );

    // Cycles since reset release, used to predict the divide-by-3 strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc3 <= 0;
        else     cyc3 <= cyc3 + 1;
    end

    // Reference step written with plain arithmetic on the 4-bit value.
    function automatic logic [3:0] model_step(input logic [2:0] mode, input logic [3:0] cur,
                                              input logic [3:0] ld, input logic si, input int count);
        int v, r;
        v = int'(cur);
        case (mode)
            3'd0: r = int'(ld);
            3'd1: r = (count == 0) ? v : (v / 2) + (si ? 8 : 0);
            3'd2: r = (count == 0) ? v : ((v * 2) % 16) + (si ? 1 : 0);
            3'd3: r = (count == 0) ? v : (v / 2) + ((v % 2) * 8);
            3'd4: r = (count == 0) ? v : ((v * 2) % 16) + (v / 8);
            3'd5: r = 0;
            default: r = v;
        endcase
        return 4'(r);
    endfunction

    function automatic int nsteps_f(input logic [2:0] mode, input int count);
        if ((mode >= 3'd1) && (mode <= 3'd4) && (count != 0)) return count;
        return 1;
    endfunction

    // Issue one command to dut (TICK_DIV=1) and check every step; si_sel 0/1 fixed, 2 random.
    task automatic do_cmd(input logic [2:0] mode, input int count, input logic [3:0] dv,
                          input int si_sel, input int abort_at, input string tag);
        int n;
        int budget;
        logic si;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: cmd_ready=%b expected 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_count = 3'(count); d_in = dv;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_accept: cmd_ready=%b expected 0", tag, cmd_ready);
        end
        n = nsteps_f(mode, count);
        for (int i = 0; i < n; i++) begin
            si = (si_sel == 2) ? 1'($urandom_range(0, 1)) : (si_sel == 1);
            ser_in = si;
            if (i == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                checks++;
                if (q !== ref_q || cmd_ready !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort: q=%b ready=%b done=%b expected q=%b ready=1 done=0",
                             tag, q, cmd_ready, done, ref_q);
                end
                return;
            end
            @(posedge clk); #1;
            ref_q = model_step(mode, ref_q, dv, si, count);
            checks++;
            if (q !== ref_q || so_lsb !== ref_q[0] || so_msb !== ref_q[3]) begin
                errors++;
                $display("FAIL %s step%0d q: got q=%b lsb=%b msb=%b expected %b",
                         tag, i, q, so_lsb, so_msb, ref_q);
            end
            checks++;
            if (done !== (i == n - 1) || cmd_ready !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s step%0d done/ready: got %b/%b expected %b",
                         tag, i, done, cmd_ready, (i == n - 1));
            end
        end
    endtask

    // Issue one command to dut3 (TICK_DIV=3) and check tick timing and step placement.
    task automatic do_cmd3(input logic [2:0] mode, input int count, input logic [3:0] dv, input string tag);
        int remaining;
        int cyc;
        logic tick_now;
        cmd_valid3 = 1'b1; cmd_mode = mode; cmd_count = 3'(count); d_in = dv;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        remaining = nsteps_f(mode, count);
        cyc = 0;
        while (remaining > 0 && cyc < 30) begin
            tick_now = tick3;
            checks++;
            if (tick3 !== ((cyc3 % 3) == 2)) begin
                errors++;
                $display("FAIL %s tick3: got %b expected %b", tag, tick3, ((cyc3 % 3) == 2));
            end
            @(posedge clk); #1;
            cyc++;
            if (tick_now) begin
                ref3 = model_step(mode, ref3, dv, 1'b0, count);
                remaining--;
            end
            checks++;
            if (q3 !== ref3 || done3 !== (tick_now && remaining == 0)) begin
                errors++;
                $display("FAIL %s q3/done3: got %b/%b expected %b/%b",
                         tag, q3, done3, ref3, (tick_now && remaining == 0));
            end
        end
        checks++;
        if (remaining != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d steps left expected 0", tag, remaining);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q !== 4'b0000 || cmd_ready !== 1'b1 || done !== 1'b0 || tick !== 1'b1 || tick3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: q=%b ready=%b done=%b tick=%b tick3=%b expected 0000 1 0 1 0",
                     q, cmd_ready, done, tick, tick3);
        end
        rst = 1'b0;
        do_cmd(3'd0, 0, 4'b1111, 0, -1, "reset_preload");
        cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_count = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (q !== 4'b0000 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: q=%b ready=%b done=%b expected 0000 1 0", q, cmd_ready, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ref_q = 4'b0000;
        ref3 = 4'b0000;
    endtask

    task automatic test_load;
        do_cmd(3'd0, 0, 4'b1011, 0, -1, "load");
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || q !== 4'b1011) begin
            errors++;
            $display("FAIL load_single_pulse: done=%b q=%b expected 0 1011", done, q);
        end
    endtask

    task automatic test_shr;
        do_cmd(3'd1, 3, 4'b0000, 0, -1, "shr_si0");
        checks++;
        if (q !== 4'b0001) begin
            errors++;
            $display("FAIL shr_si0_final: got %b expected 0001", q);
        end
        do_cmd(3'd0, 0, 4'b1011, 0, -1, "shr_reload");
        do_cmd(3'd1, 3, 4'b0000, 1, -1, "shr_si1");
        checks++;
        if (q !== 4'b1111) begin
            errors++;
            $display("FAIL shr_si1_final: got %b expected 1111", q);
        end
    endtask

    task automatic test_rol;
        do_cmd(3'd0, 0, 4'b1000, 0, -1, "rol_load");
        do_cmd(3'd4, 4, 4'b0000, 0, -1, "rol4");
        checks++;
        if (q !== 4'b1000) begin
            errors++;
            $display("FAIL rol_restore: got %b expected 1000", q);
        end
    endtask

    task automatic test_tick_div3;
        do_cmd3(3'd0, 0, 4'b0011, "tick3_load");
        do_cmd3(3'd3, 2, 4'b0000, "tick3_ror");
        checks++;
        if (q3 !== 4'b1100) begin
            errors++;
            $display("FAIL tick3_ror_final: got %b expected 1100", q3);
        end
    endtask

    task automatic test_abort;
        do_cmd(3'd0, 0, 4'b0001, 0, -1, "abort_load");
        do_cmd(3'd2, 3, 4'b0000, 0, 1, "abort_shl");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q !== 4'b0010 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: q=%b done=%b ready=%b expected 0010 0 1", q, done, cmd_ready);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (q !== 4'b0010 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_ignored: q=%b ready=%b expected 0010 1", q, cmd_ready);
        end
        do_cmd(3'd2, 1, 4'b0000, 1, 0, "abort_final_tick");
        do_cmd(3'd5, 0, 4'b0000, 0, -1, "clr");
        checks++;
        if (q !== 4'b0000) begin
            errors++;
            $display("FAIL clr_final: got %b expected 0000", q);
        end
    endtask

    task automatic test_noop_modes;
        do_cmd(3'd0, 0, 4'b0110, 0, -1, "noop_load");
        do_cmd(3'd1, 0, 4'b0000, 1, -1, "shr_count0");
        do_cmd(3'd6, 5, 4'b1111, 1, -1, "code6");
        do_cmd(3'd7, 2, 4'b1111, 1, -1, "code7");
        checks++;
        if (q !== 4'b0110) begin
            errors++;
            $display("FAIL noop_hold: got %b expected 0110", q);
        end
    endtask

    task automatic test_back_to_back;
        do_cmd(3'd0, 0, 4'b0101, 0, -1, "b2b_load");
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_window: done=%b ready=%b expected 1 1", done, cmd_ready);
        end
        do_cmd(3'd3, 1, 4'b0000, 0, -1, "b2b_ror");
        do_cmd(3'd2, 2, 4'b0000, 1, -1, "b2b_shl");
    endtask

    task automatic test_random;
        logic [2:0] m;
        int c;
        int ab;
        for (int k = 0; k < 60; k++) begin
            m = 3'($urandom_range(0, 7));
            c = int'($urandom_range(0, 7));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            do_cmd(m, c, 4'($urandom_range(0, 15)), 2, ab, "random");
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shr();
        test_rol();
        test_tick_div3();
        test_abort();
        test_noop_modes();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ushift_reg.md
# ushift_reg

Parametrised universal shift register with a built-in tick prescaler and a command handshake. It generalises the team's fixed 4-bit load/shift-right register to arbitrary width, adds shift-left, rotate and clear modes, and supports multi-step shifts with a completion pulse. All stepping is done with a single-cycle tick enable; there are no derived clocks. The block sits between board switches/buttons (or a control FSM) and LED or serial-output logic.

## Interface
Parameters:
- WIDTH, 4, register width in bits (≥2).
- TICK_DIV, 2**26, number of clk cycles per step tick (≥1). Benches override it to a small value.
- CNT_W, $clog2(WIDTH+1), width of the step-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle; the command is accepted on `cmd_valid && cmd_ready` at a posedge.
- cmd_mode  in  3  operation (mode_e).
- cmd_count  in  CNT_W  number of steps for shift/rotate modes.
- d_in  in  WIDTH  parallel load data, sampled at acceptance.
- ser_in  in  1  serial fill bit, sampled live at each step.
- abort  in  1  cancels the running command.
- q  out  WIDTH  register contents.
- so_lsb  out  1  equals q[0].
- so_msb  out  1  equals q[WIDTH-1].
- tick  out  1  prescaler strobe, for observation.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- Prescaler: a free-running counter counts 0..TICK_DIV-1 and wraps. `tick`=1 in the cycle where the counter equals TICK_DIV-1. With TICK_DIV=1, `tick` is always 1.
- The FSM has two states:
  - IDLE: cmd_ready=1.
  - RUN: cmd_ready=0.
- Acceptance: the block latches mode, remaining-step count and d_in, then enters RUN.
  - LOAD and CLR always take exactly 1 step, regardless of count.
  - Shift/rotate with count=0 takes 1 step that leaves q unchanged.
- In RUN, each tick cycle performs one step and decrements the remaining count. When the last step executes, the FSM returns to IDLE and done=1 in the following cycle, together with the updated q.
- Step semantics:
  - LOAD(0): q←d_in.
  - SHR(1): q←{ser_in, q[W-1:1]}.
  - SHL(2): q←{q[W-2:0], ser_in}.
  - ROR(3): q←{q[0], q[W-1:1]}.
  - ROL(4): q←{q[W-2:0], q[W-1]}.
  - CLR(5): q←0.
  - Codes 6 and 7 are a no-op step: q holds and done still pulses.
- Between ticks in RUN, q holds.
- abort in RUN returns the FSM to IDLE at the next edge. There is no done pulse, and q keeps its partially shifted value. If abort and the final tick coincide, abort wins: no step and no done. abort in IDLE is ignored.
- Reset values: q=0, FSM=IDLE (cmd_ready=1), done=0, prescaler=0, tick=0 (1 when TICK_DIV=1).
- Reset mid-command discards the command immediately.

## Timing
- A tick in the same cycle as acceptance is not used. The first step happens on the first tick strictly after acceptance.
- Latency with TICK_DIV=1 and N steps:
  - Accept at edge k.
  - Steps at edges k+1..k+N.
  - done and cmd_ready are both high in the cycle after edge k+N.
- Back-to-back: a new command may be accepted in the same cycle that done is high.
- cmd_valid while busy is held off by cmd_ready=0. The requester keeps its fields stable until accepted.

## Structure
- Package ushift_pkg: typedef enum logic [2:0] mode_e {MODE_LOAD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_CLR}; typedef enum logic state_e {ST_IDLE, ST_RUN}.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick). It is reusable by other board-rate blocks.
- The shift datapath and the FSM stay in ushift_reg.

## Test plan
All scenarios use WIDTH=4, TICK_DIV=1 unless stated.
- Reset: assert rst mid-RUN → q=0000, cmd_ready=1, done=0 asynchronously.
- LOAD d_in=1011 → q=1011 one edge after acceptance, done pulses once.
- SHR count=3, ser_in=0, start q=1011 → q goes 0101, 0010, 0001, then done. Repeat with ser_in=1 → 1101, 1110, 1111.
- ROL count=4 from q=1000 → 0001, 0010, 0100, 1000, then done, with q restored.
- TICK_DIV=3, ROR count=2 from 0011 → tick asserts every 3rd cycle, q changes only on ticks (1001, then 1100), done follows the second tick.
- Abort after 1 of 3 SHL steps from 0001 (ser_in=0) → q=0010 holds, no done, cmd_ready=1. A following CLR gives q=0000 with a done pulse.
